// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Contents:
//   mul_state_e      - FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   READY_TRUE/FALSE - handshake level constants
//   mul_p_width()    - product width from operand widths
//   mul_cnt_width()  - bit-counter width from multiplier width
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic READY_TRUE  = 1'b1;
    localparam logic READY_FALSE = 1'b0;

    function automatic int mul_p_width(input int xw, input int yw);
        return xw + yw;
    endfunction

    // Never below one bit so the counter always exists.
    function automatic int mul_cnt_width(input int yw);
        return (yw > 1) ? $clog2(yw) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_acc.sv
// Combinational add/subtract stage of the multiplier accumulator.
// Ports:
//   a   in  W  running accumulator value
//   b   in  W  shifted partial product
//   sub in  1  1: sum = a - b, 0: sum = a + b
//   sum out W  result, modulo 2^W
module mul_seq_acc #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    // Add or subtract the partial product; wrap-around is intended.
    always_comb begin
        sum = '0;
        if (sub) begin
            sum = a - b;
        end else begin
            sum = a + b;
        end
    end

endmodule

// File: rtl/mul_seq_xy.sv
// Sequential shift-add multiplier, X_WIDTH x Y_WIDTH -> P_WIDTH, one multiplier
// bit per cycle, valid/ready handshakes on operand and product sides.
// Optional build macro: MUL_SIGNED_EN adds the signed_mode input; with it set
// the operands are two's complement and the last step subtracts.
// Ports:
//   clk         in  1        clock, rising edge
//   rst_n       in  1        synchronous reset, active-low
//   in_valid    in  1        x/y valid
//   in_ready    out 1        ready for operands (IDLE)
//   x           in  X_WIDTH  multiplicand
//   y           in  Y_WIDTH  multiplier
//   signed_mode in  1        (MUL_SIGNED_EN only) two's-complement operands
//   out_valid   out 1        product valid (DONE)
//   out_ready   in  1        sink accepts product
//   p           out P_WIDTH  product, held while out_valid && !out_ready
//   busy        out 1        BUSY or DONE
module mul_seq_xy
    import mul_pkg::*;
#(
    parameter  int X_WIDTH = 8,
    parameter  int Y_WIDTH = 8,
    localparam int P_WIDTH = mul_p_width(X_WIDTH, Y_WIDTH),
    localparam int CNT_W   = mul_cnt_width(Y_WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
`ifdef MUL_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] p,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_e         state_r;
    mul_state_e         state_nxt_s;
    logic [P_WIDTH-1:0] xreg_r;
    logic [Y_WIDTH-1:0] yreg_r;
    logic [P_WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [P_WIDTH-1:0] pp_s;
    logic [P_WIDTH-1:0] sum_s;
    logic [P_WIDTH-1:0] xext_s;
    logic               sub_s;
    logic               accept_s;
    logic               last_s;
`ifdef MUL_SIGNED_EN
    logic               signed_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign p         = acc_r;

    assign accept_s = in_valid && (state_r == IDLE);
    assign last_s   = (cnt_r == CNT_LAST);

    // Next-state decode for the IDLE -> BUSY -> DONE -> IDLE cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Partial product for the current multiplier bit, operand extension and
    // the subtract select (only the MSB step of a signed multiply subtracts).
    always_comb begin
        pp_s   = '0;
        sub_s  = 1'b0;
        xext_s = {{Y_WIDTH{1'b0}}, x};
        if (yreg_r[cnt_r]) begin
            pp_s = xreg_r << cnt_r;
        end else begin
            pp_s = '0;
        end
`ifdef MUL_SIGNED_EN
        sub_s  = signed_r && last_s;
        xext_s = {{Y_WIDTH{signed_mode & x[X_WIDTH-1]}}, x};
`endif
    end

    mul_seq_acc #(
        .W (P_WIDTH)
    ) u_acc (
        .a   (acc_r),
        .b   (pp_s),
        .sub (sub_s),
        .sum (sum_s)
    );

    // State, operand capture, accumulation and registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            xreg_r      <= '0;
            yreg_r      <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            in_ready_r  <= READY_TRUE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef MUL_SIGNED_EN
            signed_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE) ? READY_TRUE : READY_FALSE;
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        xreg_r <= xext_s;
                        yreg_r <= y;
                        acc_r  <= '0;
                        cnt_r  <= '0;
`ifdef MUL_SIGNED_EN
                        signed_r <= signed_mode;
`endif
                    end
                end
                BUSY: begin
                    acc_r <= sum_s;
                    cnt_r <= last_s ? '0 : (cnt_r + CNT_ONE);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_xy.sv
module tb_mul_seq_xy;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_xy #(
        .X_WIDTH (8),
        .Y_WIDTH (8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
`ifdef MUL_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

`ifdef MUL_SIGNED_EN
    logic       iv3, ir3, ov3, or3, busy3, sm3;
    logic [2:0] x3, y3;
    logic [5:0] p3;

    mul_seq_xy #(
        .X_WIDTH (3),
        .Y_WIDTH (3)
    ) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (iv3),
        .in_ready    (ir3),
        .x           (x3),
        .y           (y3),
        .signed_mode (sm3),
        .out_valid   (ov3),
        .out_ready   (or3),
        .p           (p3),
        .busy        (busy3)
    );
`endif

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair while idle, wait (bounded) for out_valid,
    // return product and number of edges after acceptance; then release.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic sm,
                          output logic [15:0] res, output int lat);
        x = xa; y = ya; signed_mode = sm; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        x = 8'($urandom); y = 8'($urandom);
        lat = -1;
        res = 16'h0;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (out_valid) begin
                lat = n;
                res = p;
                break;
            end
        end
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] res;
        int          lat;
        logic [7:0]  bx[3];
        logic [7:0]  by[3];
        logic [15:0] bp[3];
        int          t_out[3];
        int          idx, got;
        logic        acc_now, seen;

        tbl[0] = '{8'd255, 8'd255, 16'hFE01};
        tbl[1] = '{8'd0,   8'd200, 16'd0};
        tbl[2] = '{8'd3,   8'd5,   16'd15};
        tbl[3] = '{8'd1,   8'd1,   16'd1};
        tbl[4] = '{8'd128, 8'd2,   16'd256};
        tbl[5] = '{8'd100, 8'd100, 16'd10000};
        tbl[6] = '{8'd255, 8'd1,   16'd255};
        tbl[7] = '{8'd1,   8'd255, 16'd255};
        tbl[8] = '{8'd170, 8'd85,  16'd14450};
        tbl[9] = '{8'd200, 8'd0,   16'd0};

        bx[0] = 8'd7;   by[0] = 8'd9;  bp[0] = 16'd63;
        bx[1] = 8'd16;  by[1] = 8'd16; bp[1] = 16'd256;
        bx[2] = 8'd254; by[2] = 8'd3;  bp[2] = 16'd762;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        signed_mode = 1'b0; x = 8'h0; y = 8'h0;
`ifdef MUL_SIGNED_EN
        iv3 = 1'b0; or3 = 1'b1; sm3 = 1'b0; x3 = 3'd0; y3 = 3'd0;
`endif

        // reset
        tick; tick;
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 0);
        chk("rst_busy", busy, 0);

        // table of unsigned vectors
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tbl%0d_ready", i), in_ready, 1);
            run_op(tbl[i].x, tbl[i].y, 1'b0, res, lat);
            chk($sformatf("tbl%0d_latency", i), lat, 8);
            chk($sformatf("tbl%0d_p", i), res, tbl[i].p);
            chk($sformatf("tbl%0d_idle", i), {busy, in_ready}, 2'b01);
        end

        // back-pressure, with ignored in_valid while DONE
        out_ready = 1'b0;
        x = 8'd12; y = 8'd11; in_valid = 1'b1;
        tick;
        chk("bp_busy_run", {busy, in_ready}, 2'b10);
        x = 8'd99; y = 8'd99;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        chk("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, busy, p}, {3'b101, 16'd132});
            tick;
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("bp_release", {out_valid, in_ready, busy}, 3'b010);
        tick;
        chk("bp_no_accept", busy, 0);

        // reset during BUSY
        x = 8'd3; y = 8'd5; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("midrst_state", {out_valid, in_ready, busy, p}, {3'b010, 16'd0});
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", seen, 0);

        // back-to-back operands with in_valid held high
        idx = 0; got = 0;
        x = bx[0]; y = by[0]; in_valid = 1'b1;
        for (int t = 0; t < 60 && got < 3; t++) begin
            acc_now = in_valid && in_ready;
            tick;
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    x = bx[idx]; y = by[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk($sformatf("b2b_p%0d", got), p, bp[got]);
                t_out[got] = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", got, 3);
        if (got == 3) begin
            chk("b2b_gap01", t_out[1] - t_out[0], 10);
            chk("b2b_gap12", t_out[2] - t_out[1], 10);
        end
        tick;

`ifdef MUL_SIGNED_EN
        run_op(8'hFF, 8'd127, 1'b1, res, lat);
        chk("s_m1x127", res, 16'hFF81);
        run_op(8'h80, 8'h80, 1'b1, res, lat);
        chk("s_m128xm128", res, 16'h4000);
        run_op(8'hFF, 8'd127, 1'b0, res, lat);
        chk("u_255x127", res, 16'h7E81);

        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    int ea, eb;
                    logic ok;
                    ea = (m == 1 && a >= 4) ? a - 8 : a;
                    eb = (m == 1 && b >= 4) ? b - 8 : b;
                    x3 = 3'(a); y3 = 3'(b); sm3 = m[0]; iv3 = 1'b1;
                    tick;
                    iv3 = 1'b0;
                    ok = 1'b0;
                    for (int n = 0; n < 10; n++) begin
                        tick;
                        if (ov3) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    chk($sformatf("x3m%0d_%0dx%0d", m, a, b), {ok, p3}, {1'b1, 6'((ea * eb) & 63)});
                    tick;
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
